// File: rtl/dmem_pkg.sv
// Shared constants and types for the data-memory responder.
// The store-counter MMIO register is built only when DMEM_STORE_COUNT_EN is defined.
package dmem_pkg;

    localparam int DMEM_DEPTH = 512;
    localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

    localparam logic [3:0] MMIO_LED   = 4'd0;
    localparam logic [3:0] MMIO_SW    = 4'd1;
    localparam logic [3:0] MMIO_CYC   = 4'd2;
    localparam logic [3:0] MMIO_STCNT = 4'd3;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM with write-first registered read.
// The contents are not reset; the parent zeroes them with its clear sequencer.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DMEM_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int DW    = 16
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Memory-write-stage responder: data RAM, 16-word MMIO window and post-reset clear sequencer.
// Define DMEM_STORE_COUNT_EN to add the store counter at MMIO offset 3.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int            DEPTH          = DMEM_DEPTH,
    parameter int            AW             = $clog2(DEPTH),
    parameter logic [AW-1:0] MMIO_BASE      = 9'h1F0,
    parameter bit            CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] addr_mem,
    input  logic [15:0]   wdata_mem,
    input  logic          write_mem,
    output logic [15:0]   rdata_mem,
    output logic          busy,
    input  logic [15:0]   sw_in,
    output logic [15:0]   led_out
);

    dmem_state_t   state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [15:0]   led_q, led_d;
    logic [15:0]   cyc_q, cyc_d;
    logic [15:0]   mmio_q, mmio_d;
    logic          ram_sel_q, ram_sel_d;

    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;

    logic          in_mmio;
    logic [AW-1:0] off_full;
    logic          mmio_hit;
    logic [3:0]    mmio_off;

`ifdef DMEM_STORE_COUNT_EN
    logic [15:0]   stcnt_q, stcnt_d;
`endif

    assign in_mmio  = (addr_mem >= MMIO_BASE);
    assign off_full = addr_mem - MMIO_BASE;
    // Offsets past the 16-word window (only possible with a non-default base) read as reserved.
    assign mmio_hit = in_mmio && (off_full[AW-1:4] == '0);
    assign mmio_off = off_full[3:0];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        led_d     = led_q;
        cyc_d     = cyc_q;
        mmio_d    = '0;
        ram_sel_d = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = addr_mem;
        ram_wdata = wdata_mem;
`ifdef DMEM_STORE_COUNT_EN
        stcnt_d   = stcnt_q;
`endif
        if (state_q == CLEAR) begin
            ram_we    = 1'b1;
            ram_addr  = ptr_q;
            ram_wdata = '0;
            ptr_d     = ptr_q + AW'(1);
            if (ptr_q == AW'(DEPTH - 1)) begin
                state_d = RUN;
            end
        end else begin
            cyc_d = cyc_q + 16'd1;
`ifdef DMEM_STORE_COUNT_EN
            if (write_mem) begin
                stcnt_d = (mmio_hit && mmio_off == MMIO_STCNT) ? 16'd0 : stcnt_q + 16'd1;
            end
`endif
            if (!in_mmio) begin
                ram_we    = write_mem;
                ram_sel_d = 1'b1;
            end else if (mmio_hit) begin
                case (mmio_off)
                    MMIO_LED: begin
                        if (write_mem) begin
                            led_d = wdata_mem;
                        end
                        mmio_d = write_mem ? wdata_mem : led_q;
                    end
                    MMIO_SW:  mmio_d = sw_in;
                    MMIO_CYC: mmio_d = cyc_q;
`ifdef DMEM_STORE_COUNT_EN
                    MMIO_STCNT: mmio_d = write_mem ? 16'd0 : stcnt_q;
`endif
                    default:  mmio_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= CLEAR_ON_RESET ? CLEAR : RUN;
            ptr_q     <= '0;
            led_q     <= '0;
            cyc_q     <= '0;
            mmio_q    <= '0;
            ram_sel_q <= 1'b0;
`ifdef DMEM_STORE_COUNT_EN
            stcnt_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            led_q     <= led_d;
            cyc_q     <= cyc_d;
            mmio_q    <= mmio_d;
            ram_sel_q <= ram_sel_d;
`ifdef DMEM_STORE_COUNT_EN
            stcnt_q   <= stcnt_d;
`endif
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (16)
    ) u_array (
        .clk_i   (clk),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // RAM read data is only selected for a RUN-cycle RAM access, so CLEAR and reset read as zero.
    assign rdata_mem = ram_sel_q ? ram_rdata : mmio_q;
    assign busy      = (state_q == CLEAR);
    assign led_out   = led_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a cycle-level behavioural model.
module tb_data_mem_responder;

    localparam int         DEPTH = 512;
    localparam logic [8:0] BASE  = 9'h1F0;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [8:0]  addr_mem = '0;
    logic [15:0] wdata_mem = '0;
    logic        write_mem = 1'b0;
    logic [15:0] rdata_mem;
    logic        busy;
    logic [15:0] sw_in = '0;
    logic [15:0] led_out;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model state
    logic [15:0] m_ram [DEPTH];
    logic [15:0] m_led, m_cyc, m_stc, exp_rd;
    int          m_clr;
    bit          m_run;

    data_mem_responder dut (
        .clk       (clk),
        .rst       (rst),
        .addr_mem  (addr_mem),
        .wdata_mem (wdata_mem),
        .write_mem (write_mem),
        .rdata_mem (rdata_mem),
        .busy      (busy),
        .sw_in     (sw_in),
        .led_out   (led_out)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_clr  = 0;
        m_run  = 1'b0;
        m_led  = '0;
        m_cyc  = '0;
        m_stc  = '0;
        exp_rd = '0;
    endtask

    // Apply one access for one clock and advance the model by the same edge.
    task automatic step(input logic [8:0] a, input logic [15:0] w, input logic we);
        int off;
        addr_mem  = a;
        wdata_mem = w;
        write_mem = we;
        @(posedge clk);
        #1;
        if (!m_run) begin
            m_clr++;
            exp_rd = '0;
            if (m_clr == DEPTH) begin
                m_run = 1'b1;
                for (int i = 0; i < DEPTH; i++) m_ram[i] = '0;
            end
        end else begin
            if (a < BASE) begin
                if (we) m_ram[a] = w;
                exp_rd = m_ram[a];
            end else begin
                off    = int'(a) - int'(BASE);
                exp_rd = '0;
                if (off == 0) begin
                    if (we) m_led = w;
                    exp_rd = m_led;
                end else if (off == 1) begin
                    exp_rd = sw_in;
                end else if (off == 2) begin
                    exp_rd = m_cyc;
                end
`ifdef DMEM_STORE_COUNT_EN
                else if (off == 3) begin
                    if (we) m_stc = '0;
                    exp_rd = m_stc;
                end
`endif
            end
`ifdef DMEM_STORE_COUNT_EN
            if (we && a != BASE + 9'd3) m_stc++;
`endif
            m_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        #1;
        n_total++;
        if (busy !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy); else n_pass++;
        n_total++;
        if (rdata_mem !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", rdata_mem); else n_pass++;
        n_total++;
        if (led_out !== 16'h0000) $display("FAIL reset_led: got %h want 0000", led_out); else n_pass++;
    endtask

    task automatic test_reset_clear();
        int n;
        bit nz;
        logic [8:0] addrs [3];
        addrs[0] = 9'h000;
        addrs[1] = 9'h0FF;
        addrs[2] = 9'h1EF;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        n = 0;
        nz = 1'b0;
        do begin
            step(9'($urandom_range(0, 511)), 16'($urandom), 1'b1);
            n++;
            if (busy && rdata_mem !== 16'h0000) nz = 1'b1;
        end while (busy && n < 2000);
        n_total++;
        if (n != 512) $display("FAIL first_clear_len: got %0d cycles want 512", n); else n_pass++;
        n_total++;
        if (nz) $display("FAIL rdata_during_clear: got nonzero want 0000"); else n_pass++;
        // Dirty the RAM through the front door, then check a second reset wipes it.
        for (int i = 0; i < 3; i++) step(addrs[i], 16'hA5A5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(addrs[i], 16'h0000, 1'b0);
            n_total++;
            if (rdata_mem !== 16'hA5A5) $display("FAIL preload_%0d: got %h want a5a5", i, rdata_mem); else n_pass++;
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        n = 0;
        do begin
            step(9'h010, 16'hFFFF, 1'b1);
            n++;
        end while (busy && n < 2000);
        n_total++;
        if (n != 512) $display("FAIL second_clear_len: got %0d cycles want 512", n); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step(addrs[i], 16'h0000, 1'b0);
            n_total++;
            if (rdata_mem !== 16'h0000) $display("FAIL cleared_%0d: got %h want 0000", i, rdata_mem); else n_pass++;
        end
    endtask

    task automatic test_store_load();
        step(9'h010, 16'h1234, 1'b1);
        step(9'h010, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h1234) $display("FAIL load_010: got %h want 1234", rdata_mem); else n_pass++;
        step(9'h011, 16'hBEEF, 1'b1);
        n_total++;
        if (rdata_mem !== 16'hBEEF) $display("FAIL write_first: got %h want beef", rdata_mem); else n_pass++;
    endtask

    task automatic test_mmio();
        step(9'h1F0, 16'h00FF, 1'b1);
        n_total++;
        if (led_out !== 16'h00FF) $display("FAIL led_write: got %h want 00ff", led_out); else n_pass++;
        n_total++;
        if (dut.u_array.mem_q[9'h1F0] !== 16'h0000)
            $display("FAIL mmio_alias: got %h want 0000", dut.u_array.mem_q[9'h1F0]);
        else n_pass++;
        step(9'h1F0, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h00FF) $display("FAIL led_read: got %h want 00ff", rdata_mem); else n_pass++;
        sw_in = 16'h8001;
        step(9'h1F1, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h8001) $display("FAIL sw_read: got %h want 8001", rdata_mem); else n_pass++;
        step(9'h1F1, 16'h5555, 1'b1);
        n_total++;
        if (rdata_mem !== 16'h8001 || led_out !== 16'h00FF)
            $display("FAIL sw_write: got rd=%h led=%h want rd=8001 led=00ff", rdata_mem, led_out);
        else n_pass++;
        step(9'h1F7, 16'h7777, 1'b1);
        n_total++;
        if (rdata_mem !== 16'h0000) $display("FAIL reserved_read: got %h want 0000", rdata_mem); else n_pass++;
    endtask

    task automatic test_cycle_counter();
        logic [15:0] v1, v2;
        step(9'h1F2, 16'h0000, 1'b0);
        v1 = rdata_mem;
        n_total++;
        if (v1 !== exp_rd) $display("FAIL cyc_value: got %h want %h", v1, exp_rd); else n_pass++;
        repeat (9) step(9'h020, 16'h0000, 1'b0);
        step(9'h1F2, 16'h0000, 1'b0);
        v2 = rdata_mem;
        n_total++;
        if ((v2 - v1) !== 16'd10) $display("FAIL cyc_delta: got %0d want 10", v2 - v1); else n_pass++;
    endtask

    task automatic test_store_count();
        step(9'h1F3, 16'h0000, 1'b1);
        for (int i = 0; i < 5; i++) step(9'($urandom_range(0, 200)), 16'($urandom), 1'b1);
        step(9'h1F3, 16'h0000, 1'b0);
        n_total++;
`ifdef DMEM_STORE_COUNT_EN
        if (rdata_mem !== 16'h0005) $display("FAIL stcnt_five: got %h want 0005", rdata_mem); else n_pass++;
`else
        if (rdata_mem !== 16'h0000) $display("FAIL stcnt_absent: got %h want 0000", rdata_mem); else n_pass++;
`endif
        step(9'h1F3, 16'hABCD, 1'b1);
        step(9'h1F3, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h0000) $display("FAIL stcnt_clear: got %h want 0000", rdata_mem); else n_pass++;
    endtask

    task automatic test_random();
        logic [8:0] a;
        int bad_rd, bad_led;
        bad_rd = 0;
        bad_led = 0;
        for (int i = 0; i < 400; i++) begin
            sw_in = 16'($urandom);
            case ($urandom_range(0, 3))
                0: a = BASE + 9'($urandom_range(0, 15));
                1: a = 9'($urandom_range(0, int'(BASE) - 1));
                default: a = 9'($urandom_range(0, 15));
            endcase
            step(a, 16'($urandom), 1'($urandom));
            n_total++;
            if (rdata_mem !== exp_rd || led_out !== m_led) begin
                if (bad_rd + bad_led < 5)
                    $display("FAIL random_%0d addr=%h: got rd=%h led=%h want rd=%h led=%h",
                             i, a, rdata_mem, led_out, exp_rd, m_led);
                if (rdata_mem !== exp_rd) bad_rd++; else bad_led++;
            end else n_pass++;
        end
    endtask

    task automatic test_mid_clear_reset();
        int n;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (200) step(9'h005, 16'h1111, 1'b1);
        n_total++;
        if (busy !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy); else n_pass++;
        rst = 1'b0;
        #1;
        n_total++;
        if (busy !== 1'b1 || rdata_mem !== 16'h0000)
            $display("FAIL mid_in_reset: got busy=%b rd=%h want busy=1 rd=0000", busy, rdata_mem);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        n = 0;
        do begin
            step(9'h005, 16'h2222, 1'b1);
            n++;
        end while (busy && n < 2000);
        n_total++;
        if (n != 512) $display("FAIL mid_clear_len: got %0d cycles want 512", n); else n_pass++;
        step(9'h005, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h0000) $display("FAIL mid_cleared: got %h want 0000", rdata_mem); else n_pass++;
    endtask

    task automatic test_cycle_wrap();
        int guard;
        guard = 0;
        while (m_cyc != 16'hFFFF && guard < 70000) begin
            step(9'h020, 16'h0000, 1'b0);
            guard++;
        end
        step(9'h1F2, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'hFFFF) $display("FAIL cyc_max: got %h want ffff", rdata_mem); else n_pass++;
        step(9'h1F2, 16'h0000, 1'b0);
        n_total++;
        if (rdata_mem !== 16'h0000) $display("FAIL cyc_wrap: got %h want 0000", rdata_mem); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_reset_clear();
        test_store_load();
        test_mmio();
        test_cycle_counter();
        test_store_count();
        test_random();
        test_mid_clear_reset();
        test_cycle_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
